hwpe_stream_protocol_checker: RTL and testbench
===============================================

# hwpe_stream_protocol_checker

Synthesisable, parametrised protocol checker for HWPE streams and TCDM ports, generalising the simulation-only interface assertions to N stream channels, M TCDM channels and a configurable TCDM read latency. It sits beside any streamer or engine as a passive observer on `monitor` modports. It exposes sticky per-channel error flags and saturating handshake counters, so that violations are visible in silicon and to the register file.

## Interface
Parameters:
- `NB_STREAM`, 2: number of observed stream channels (≥1).
- `DATA_WIDTH`, 32: stream data width. Must equal the `DATA_WIDTH` of every observed stream interface. `DATA_WIDTH` is a multiple of 8.
- `NB_TCDM`, 1: number of observed TCDM channels (≥1).
- `TCDM_LATENCY`, 1: cycles from read handshake to `r_valid` (1..8).
- `CNT_WIDTH`, 16: handshake counter width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `clear_i`, in, 1: synchronous clear of flags, counters and history.
- `enable_i`, in, 1: checking and counting enable.
- `stream_i`, in, `NB_STREAM`× `hwpe_stream_intf_stream.monitor`: observed streams.
- `tcdm_i`, in, `NB_TCDM`× `hwpe_stream_intf_tcdm.monitor`: observed TCDM ports.
- `err_vcr_o`, out, `NB_STREAM`: sticky value-change violation, per stream.
- `err_vdr_o`, out, `NB_STREAM`: sticky valid-deassert violation, per stream.
- `err_miss_o`, out, `NB_TCDM`: sticky flag, `r_valid` missing after a read handshake.
- `err_spur_o`, out, `NB_TCDM`: sticky flag, `r_valid` with no pending read.
- `err_o`, out, 1: OR of all sticky flags.
- `hs_count_o`, out, `NB_STREAM`×`CNT_WIDTH`: saturating count of stream handshakes.

## Operation
- **Per-stream history:** registers `valid`, `ready`, `data`, `strb` every cycle, regardless of `enable_i`.
- **Value-change (VCR) rule:** `p_valid & ~p_ready` and current (`data`,`strb`) ≠ past → set `err_vcr_o[i]`.
- **Valid-deassert (VDR) rule:** `p_valid & ~valid & ~p_ready` → set `err_vdr_o[i]`.
- **Handshake counter:** `valid & ready` increments `hs_count_o[i]`. It saturates at 2^CNT_WIDTH−1 with no wrap.
- **Per-TCDM pending shift register:** `TCDM_LATENCY` bits deep. The bit shifted in is `req & gnt & wen`.
  - Oldest bit set and `r_valid`=0 → set `err_miss_o[j]`.
  - Oldest bit clear and `r_valid`=1 → set `err_spur_o[j]`.
- **Enable:** checks and counting happen only while `enable_i`=1. History and the pending shift register always update.
- **Sticky flags:** flags stay set until `clear_i` or `rst_i`.
- **Clear:** `clear_i` zeroes flags, counters, valid/ready history and the pending shift register.
  - `clear_i` wins over a same-cycle violation or handshake, which is discarded.
  - The cycle after clear compares against zeroed history, so no false VCR/VDR fires.

## Timing
- All outputs are registered. A violation present in cycle t shows on its flag and on `err_o` from cycle t+1.
- A handshake in cycle t is counted in `hs_count_o` from cycle t+1.
- Reset values: all flags 0, `err_o`=0, all counters 0, all history and pending bits 0. The first cycle after reset deassertion therefore fires nothing.
- The TCDM read handshake in cycle t expects `r_valid` in cycle t+`TCDM_LATENCY`.
  - Back-to-back reads each expect their own `r_valid`.
  - Reads issued while `enable_i`=0 are still tracked. An expectation falling due while `enable_i`=1 is checked.
- Write handshakes (`wen`=0) create no expectation.
- Multiple simultaneous violations on different channels each set their own flag in the same cycle.
- `rst_i` asserted mid-transaction clears everything immediately, without waiting for a clock edge.

## Structure
- Add a packed struct `hwpe_stream_checker_err_t` (`vcr`, `vdr`, `miss`, `spur`) to `hwpe_stream_package`, plus the constant `HWPE_STREAM_CHECKER_MAX_LAT = 8`.
- One sub-module, `hwpe_stream_checker_lane`: the per-stream history, VCR/VDR checks and counter. It is generated `NB_STREAM` times.
- The TCDM pending logic stays inline in a generate loop.

## Test plan
- **Stall hold:** 0xA5A5_0001 held with `valid`=1 `ready`=0 for 3 cycles, then `ready`=1 → no flags; `hs_count_o[0]`=1.
- **Data change while stalled:** stream 1 changes data 0x10→0x11 while stalled → `err_vcr_o`=2'b10 next cycle; `err_o`=1 and stays set; `clear_i` → 0.
- **Valid drop:** `valid` dropped without a handshake on stream 0 → `err_vdr_o[0]`=1; stream 1 unaffected.
- **TCDM latency:** `TCDM_LATENCY`=3, reads at cycles 5, 6 with `r_valid` at 8, 9 → no flags.
  - `r_valid` only at 8 → `err_miss_o`=1 at cycle 10.
  - Extra `r_valid` at 12 → `err_spur_o`=1 at cycle 13.
- **Saturation:** `CNT_WIDTH`=4 with 20 consecutive handshakes → `hs_count_o`=15.
  - `enable_i`=0 during a stall violation → no flag.
- **Reset and clear edges:** `rst_i` pulsed mid-stall → all outputs 0, no flag on first post-reset cycle.
  - `clear_i` coincident with a violation → flag stays 0.

Source files
------------

// File: rtl/hwpe_stream_protocol_checker_pkg.sv
// ============================================================================
// hwpe_stream_package : shared types and constants for the HWPE stream checker
// Rev 1.0
// ============================================================================
`default_nettype none

package hwpe_stream_package;

    localparam int unsigned HWPE_STREAM_CHECKER_MAX_LAT = 8;

    typedef struct packed {
        logic vcr;
        logic vdr;
        logic miss;
        logic spur;
    } hwpe_stream_checker_err_t;

endpackage

`default_nettype wire

// File: rtl/hwpe_stream_intf_stream.sv
// ============================================================================
// hwpe_stream_intf_stream : valid/ready stream interface with byte strobes
// Rev 1.0
// ============================================================================
`default_nettype none

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source  (output valid, output data, output strb, input  ready);
    modport sink    (input  valid, input  data, input  strb, output ready);
    modport monitor (input  valid, input  data, input  strb, input  ready);
endinterface

`default_nettype wire

// File: rtl/hwpe_stream_intf_tcdm.sv
// ============================================================================
// hwpe_stream_intf_tcdm : TCDM request/response port
// Rev 1.0
// ============================================================================
`default_nettype none

interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master  (output req, output add, output wen, output be, output data,
                     input  gnt, input  r_data, input r_valid);
    modport slave   (input  req, input  add, input  wen, input  be, input  data,
                     output gnt, output r_data, output r_valid);
    modport monitor (input  req, input  add, input  wen, input  be, input  data,
                     input  gnt, input  r_data, input  r_valid);
endinterface

`default_nettype wire

// File: rtl/hwpe_stream_checker_lane.sv
// ============================================================================
// hwpe_stream_checker_lane : per-stream history, VCR/VDR checks, hs counter
// Rev 1.0
// ============================================================================
`default_nettype none

module hwpe_stream_checker_lane #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_enable,
    input  logic                    i_valid,
    input  logic                    i_ready,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    output logic                    o_err_vcr,
    output logic                    o_err_vdr,
    output logic [CNT_WIDTH-1:0]    o_hs_count
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    logic                    r_p_valid;
    logic                    r_p_ready;
    logic [DATA_WIDTH-1:0]   r_p_data;
    logic [DATA_WIDTH/8-1:0] r_p_strb;
    logic                    r_err_vcr;
    logic                    r_err_vdr;
    logic [CNT_WIDTH-1:0]    r_hs_count;

    logic w_stalled;
    logic w_vcr;
    logic w_vdr;
    logic w_hs;

    assign w_stalled = r_p_valid & ~r_p_ready;
    assign w_vcr     = i_enable & w_stalled & ((i_data != r_p_data) | (i_strb != r_p_strb));
    assign w_vdr     = i_enable & w_stalled & ~i_valid;
    assign w_hs      = i_enable & i_valid & i_ready;

    // Data/strb keep tracking through a clear; a zeroed valid masks them next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_valid <= 1'b0;
            r_p_ready <= 1'b0;
            r_p_data  <= '0;
            r_p_strb  <= '0;
        end else begin
            r_p_valid <= i_clear ? 1'b0 : i_valid;
            r_p_ready <= i_clear ? 1'b0 : i_ready;
            r_p_data  <= i_data;
            r_p_strb  <= i_strb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_vcr  <= 1'b0;
            r_err_vdr  <= 1'b0;
            r_hs_count <= '0;
        end else if (i_clear) begin
            r_err_vcr  <= 1'b0;
            r_err_vdr  <= 1'b0;
            r_hs_count <= '0;
        end else begin
            r_err_vcr <= r_err_vcr | w_vcr;
            r_err_vdr <= r_err_vdr | w_vdr;
            if (w_hs && (r_hs_count != c_CNT_MAX)) begin
                r_hs_count <= r_hs_count + 1'b1;
            end
        end
    end

    assign o_err_vcr  = r_err_vcr;
    assign o_err_vdr  = r_err_vdr;
    assign o_hs_count = r_hs_count;

endmodule

`default_nettype wire

// File: rtl/hwpe_stream_protocol_checker.sv
// ============================================================================
// hwpe_stream_protocol_checker : passive checker for N streams and M TCDM ports
// Rev 1.0
// ============================================================================
`default_nettype none

module hwpe_stream_protocol_checker
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_STREAM    = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NB_TCDM      = 1,
    parameter int unsigned TCDM_LATENCY = 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    input  logic                                enable_i,
    hwpe_stream_intf_stream.monitor             stream_i [NB_STREAM-1:0],
    hwpe_stream_intf_tcdm.monitor               tcdm_i   [NB_TCDM-1:0],
    output logic [NB_STREAM-1:0]                err_vcr_o,
    output logic [NB_STREAM-1:0]                err_vdr_o,
    output logic [NB_TCDM-1:0]                  err_miss_o,
    output logic [NB_TCDM-1:0]                  err_spur_o,
    output logic                                err_o,
    output logic [NB_STREAM-1:0][CNT_WIDTH-1:0] hs_count_o
);

    localparam int unsigned c_LAT =
        (TCDM_LATENCY > HWPE_STREAM_CHECKER_MAX_LAT) ? HWPE_STREAM_CHECKER_MAX_LAT :
        (TCDM_LATENCY < 1)                           ? 1 : TCDM_LATENCY;

    hwpe_stream_checker_err_t w_err_any;

    for (genvar i = 0; i < NB_STREAM; i++) begin : g_lane
        hwpe_stream_checker_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_lane (
            .clk        (clk_i),
            .rst        (rst_i),
            .i_clear    (clear_i),
            .i_enable   (enable_i),
            .i_valid    (stream_i[i].valid),
            .i_ready    (stream_i[i].ready),
            .i_data     (stream_i[i].data),
            .i_strb     (stream_i[i].strb),
            .o_err_vcr  (err_vcr_o[i]),
            .o_err_vdr  (err_vdr_o[i]),
            .o_hs_count (hs_count_o[i])
        );
    end

    // Bit k of r_pend is a read issued k+1 cycles ago; the MSB is due this cycle.
    for (genvar j = 0; j < NB_TCDM; j++) begin : g_tcdm
        logic [c_LAT-1:0] r_pend;
        logic [c_LAT-1:0] w_pend_nxt;
        logic             r_miss;
        logic             r_spur;
        logic             w_rd_hs;
        logic             w_due;

        assign w_rd_hs = tcdm_i[j].req & tcdm_i[j].gnt & tcdm_i[j].wen;
        assign w_due   = r_pend[c_LAT-1];

        always_comb begin
            w_pend_nxt    = r_pend << 1;
            w_pend_nxt[0] = w_rd_hs;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_pend <= '0;
                r_miss <= 1'b0;
                r_spur <= 1'b0;
            end else if (clear_i) begin
                r_pend <= '0;
                r_miss <= 1'b0;
                r_spur <= 1'b0;
            end else begin
                r_pend <= w_pend_nxt;
                r_miss <= r_miss | (enable_i &  w_due & ~tcdm_i[j].r_valid);
                r_spur <= r_spur | (enable_i & ~w_due &  tcdm_i[j].r_valid);
            end
        end

        assign err_miss_o[j] = r_miss;
        assign err_spur_o[j] = r_spur;
    end

    assign w_err_any.vcr  = |err_vcr_o;
    assign w_err_any.vdr  = |err_vdr_o;
    assign w_err_any.miss = |err_miss_o;
    assign w_err_any.spur = |err_spur_o;
    assign err_o          = |w_err_any;

endmodule

`default_nettype wire

// File: tb/tb_hwpe_stream_protocol_checker.sv
// ============================================================================
// tb_hwpe_stream_protocol_checker : directed + random bench with a cycle model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hwpe_stream_protocol_checker;

    localparam int NB_S = 2;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int NB_T = 2;
    localparam int LAT  = 3;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst, clear, enable;

    logic          s_valid [NB_S];
    logic          s_ready [NB_S];
    logic [DW-1:0] s_data  [NB_S];
    logic [SW-1:0] s_strb  [NB_S];
    logic          t_req   [NB_T];
    logic          t_gnt   [NB_T];
    logic          t_wen   [NB_T];
    logic          t_rvalid[NB_T];
    logic [31:0]   t_add   [NB_T];

    logic [NB_S-1:0]         err_vcr, err_vdr;
    logic [NB_T-1:0]         err_miss, err_spur;
    logic                    err_any;
    logic [NB_S-1:0][CW-1:0] hs_count;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) s_if [NB_S-1:0] ();
    hwpe_stream_intf_tcdm                      t_if [NB_T-1:0] ();

    for (genvar g = 0; g < NB_S; g++) begin : g_sdrv
        assign s_if[g].valid = s_valid[g];
        assign s_if[g].ready = s_ready[g];
        assign s_if[g].data  = s_data[g];
        assign s_if[g].strb  = s_strb[g];
    end
    for (genvar g = 0; g < NB_T; g++) begin : g_tdrv
        assign t_if[g].req     = t_req[g];
        assign t_if[g].gnt     = t_gnt[g];
        assign t_if[g].wen     = t_wen[g];
        assign t_if[g].add     = t_add[g];
        assign t_if[g].be      = 4'hF;
        assign t_if[g].data    = t_add[g] ^ 32'h5A5A_5A5A;
        assign t_if[g].r_data  = 32'h0;
        assign t_if[g].r_valid = t_rvalid[g];
    end

    hwpe_stream_protocol_checker #(
        .NB_STREAM    (NB_S),
        .DATA_WIDTH   (DW),
        .NB_TCDM      (NB_T),
        .TCDM_LATENCY (LAT),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (clear),
        .enable_i   (enable),
        .stream_i   (s_if),
        .tcdm_i     (t_if),
        .err_vcr_o  (err_vcr),
        .err_vdr_o  (err_vdr),
        .err_miss_o (err_miss),
        .err_spur_o (err_spur),
        .err_o      (err_any),
        .hs_count_o (hs_count)
    );

    always #5 clk = ~clk;

    // Reference model: sticky flags, counters, previous-cycle stream sample,
    // and per-TCDM queues of absolute cycle numbers at which r_valid is owed.
    logic [NB_S-1:0] m_vcr, m_vdr;
    logic [NB_T-1:0] m_miss, m_spur;
    int              m_cnt  [NB_S];
    logic            p_valid[NB_S];
    logic            p_ready[NB_S];
    logic [DW-1:0]   p_data [NB_S];
    logic [SW-1:0]   p_strb [NB_S];
    int              due_q  [NB_T][$];
    int              cyc;
    int              n_cmp = 0;
    int              n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_vcr = '0; m_vdr = '0; m_miss = '0; m_spur = '0;
        for (int i = 0; i < NB_S; i++) begin
            m_cnt[i] = 0; p_valid[i] = 1'b0; p_ready[i] = 1'b0;
            p_data[i] = '0; p_strb[i] = '0;
        end
        for (int j = 0; j < NB_T; j++) due_q[j].delete();
    endtask

    function automatic bit due_now(input int j);
        return (due_q[j].size() > 0) && (due_q[j][0] == cyc);
    endfunction

    task automatic model_update();
        for (int i = 0; i < NB_S; i++) begin
            bit stalled, vcr, vdr, hs;
            stalled = p_valid[i] && !p_ready[i];
            vcr = enable && stalled && ((s_data[i] != p_data[i]) || (s_strb[i] != p_strb[i]));
            vdr = enable && stalled && !s_valid[i];
            hs  = enable && s_valid[i] && s_ready[i];
            if (clear) begin
                m_vcr[i] = 1'b0; m_vdr[i] = 1'b0; m_cnt[i] = 0;
                p_valid[i] = 1'b0; p_ready[i] = 1'b0;
            end else begin
                if (vcr) m_vcr[i] = 1'b1;
                if (vdr) m_vdr[i] = 1'b1;
                if (hs && m_cnt[i] < CMAX) m_cnt[i]++;
                p_valid[i] = s_valid[i]; p_ready[i] = s_ready[i];
            end
            p_data[i] = s_data[i]; p_strb[i] = s_strb[i];
        end
        for (int j = 0; j < NB_T; j++) begin
            bit due;
            due = due_now(j);
            if (due) void'(due_q[j].pop_front());
            if (clear) begin
                m_miss[j] = 1'b0; m_spur[j] = 1'b0;
                due_q[j].delete();
            end else begin
                if (enable && due && !t_rvalid[j]) m_miss[j] = 1'b1;
                if (enable && !due && t_rvalid[j]) m_spur[j] = 1'b1;
                if (t_req[j] && t_gnt[j] && t_wen[j]) due_q[j].push_back(cyc + LAT);
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        check("err_vcr",  32'(err_vcr),  32'(m_vcr));
        check("err_vdr",  32'(err_vdr),  32'(m_vdr));
        check("err_miss", 32'(err_miss), 32'(m_miss));
        check("err_spur", 32'(err_spur), 32'(m_spur));
        check("err_o",    32'(err_any),  32'(|{m_vcr, m_vdr, m_miss, m_spur}));
        for (int i = 0; i < NB_S; i++)
            check($sformatf("hs_count[%0d]", i), 32'(hs_count[i]), 32'(m_cnt[i]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NB_S; i++) begin
            s_valid[i] = 1'b0; s_ready[i] = 1'b0; s_data[i] = '0; s_strb[i] = '0;
        end
        for (int j = 0; j < NB_T; j++) begin
            t_req[j] = 1'b0; t_gnt[j] = 1'b0; t_wen[j] = 1'b0; t_rvalid[j] = 1'b0;
            t_add[j] = '0;
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; enable = 1'b1; cyc = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        step(); step();

        // Stall hold, then handshake
        s_valid[0] = 1'b1; s_ready[0] = 1'b0; s_data[0] = 32'hA5A5_0001; s_strb[0] = 4'hF;
        repeat (3) step();
        s_ready[0] = 1'b1; step();
        s_valid[0] = 1'b0; s_ready[0] = 1'b0; step();
        check("stall_hold_err_o", 32'(err_any), 32'd0);
        check("stall_hold_cnt0", 32'(hs_count[0]), 32'd1);

        // Data change while stalled on stream 1
        s_valid[1] = 1'b1; s_data[1] = 32'h10; s_strb[1] = 4'hF; step();
        s_data[1] = 32'h11; step();
        check("vcr_stream1", 32'(err_vcr), 32'b10);
        s_ready[1] = 1'b1; step();
        s_valid[1] = 1'b0; s_ready[1] = 1'b0; step(); step();
        check("vcr_sticky_err_o", 32'(err_any), 32'd1);
        clear = 1'b1; step(); clear = 1'b0;
        check("clear_err_o", 32'(err_any), 32'd0);
        step();

        // Valid dropped without handshake on stream 0
        s_valid[0] = 1'b1; s_data[0] = 32'h77; step();
        s_valid[0] = 1'b0; step();
        check("vdr_stream0", 32'(err_vdr), 32'b01);
        clear = 1'b1; step(); clear = 1'b0;

        // TCDM: back-to-back reads answered on time; ch1 issues a write only
        t_req[0] = 1'b1; t_gnt[0] = 1'b1; t_wen[0] = 1'b1;
        t_req[1] = 1'b1; t_gnt[1] = 1'b1; t_wen[1] = 1'b0;
        step(); t_req[1] = 1'b0; step();
        t_req[0] = 1'b0; step();
        t_rvalid[0] = 1'b1; step(); step();
        t_rvalid[0] = 1'b0; step(); step();
        check("tcdm_ok_miss", 32'(err_miss), 32'd0);
        check("tcdm_ok_spur", 32'(err_spur), 32'd0);
        // Second read's r_valid is missing
        t_req[0] = 1'b1; step(); step();
        t_req[0] = 1'b0; step();
        t_rvalid[0] = 1'b1; step();
        t_rvalid[0] = 1'b0; step();
        check("tcdm_miss", 32'(err_miss), 32'b01);
        step(); step();
        t_rvalid[0] = 1'b1; step();
        t_rvalid[0] = 1'b0;
        check("tcdm_spur", 32'(err_spur), 32'b01);
        clear = 1'b1; step(); clear = 1'b0;

        // Counter saturation
        s_valid[0] = 1'b1; s_ready[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            s_data[0] = $urandom; step();
        end
        check("saturate_cnt0", 32'(hs_count[0]), 32'd15);
        s_valid[0] = 1'b0; s_ready[0] = 1'b0; step();

        // Violations while disabled are ignored
        enable = 1'b0;
        s_valid[1] = 1'b1; s_data[1] = 32'h1; step();
        s_data[1] = 32'h2; step();
        s_valid[1] = 1'b0; step();
        enable = 1'b1; step();
        check("disabled_err_o", 32'(err_any), 32'd0);

        // Asynchronous reset mid-stall
        s_valid[0] = 1'b1; s_data[0] = 32'hCAFE; step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_err_o", 32'(err_any), 32'd0);
        check("async_rst_cnt0", 32'(hs_count[0]), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_err_o", 32'(err_any), 32'd0);

        // Clear coincident with a violation
        s_data[0] = 32'hBEEF; clear = 1'b1; step(); clear = 1'b0;
        check("clear_wins_vcr", 32'(err_vcr), 32'd0);
        step();
        s_ready[0] = 1'b1; step();
        idle_inputs(); step();

        // Randomized phase against the model
        for (int k = 0; k < 500; k++) begin
            clear  = ($urandom_range(0, 24) == 0);
            enable = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NB_S; i++) begin
                if (p_valid[i] && !p_ready[i] && $urandom_range(0, 9) != 0) begin
                    s_valid[i] = 1'b1;
                end else begin
                    s_valid[i] = $urandom_range(0, 1);
                    s_data[i]  = $urandom_range(0, 2);
                    s_strb[i]  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
                end
                s_ready[i] = $urandom_range(0, 1);
            end
            for (int j = 0; j < NB_T; j++) begin
                t_req[j]    = $urandom_range(0, 1);
                t_gnt[j]    = $urandom_range(0, 1);
                t_wen[j]    = $urandom_range(0, 1);
                t_add[j]    = $urandom;
                t_rvalid[j] = due_now(j) ? ($urandom_range(0, 19) != 0)
                                         : ($urandom_range(0, 29) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
